i2c_write_sequencer: RTL and testbench

Sequencer and arbiter in front of the single-byte I2C write engine (`NUM_WRITE_BYTES=1`).
- After reset it replays a fixed initialisation table of register writes into the engine, one transaction at a time.
- It then shares the engine between `NUM_REQ` runtime requesters using round-robin arbitration.
- It owns the engine's `start`, `device_address`, `register_address` and `data_in` inputs and observes its `done` output. Everything runs in the `scl_clock` domain.

---
 rtl/i2c_seq_pkg.sv | 20 ++
 rtl/i2c_write_sequencer_rr_arbiter.sv | 32 +++
 rtl/i2c_write_sequencer.sv | 172 +++++++++++++++++
 tb/tb_i2c_write_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C write sequencer: state encoding and
// the {dev[6:0], reg[7:0], data[7:0]} payload layout.
package i2c_seq_pkg;

    localparam int ENTRY_W     = 23;
    localparam int DEV_LSB     = 16;
    localparam int REG_LSB     = 8;
    localparam int DATA_LSB    = 0;
    localparam int ARM_TIMEOUT = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_ARM    = 3'd3,
        ST_RUN    = 3'd4,
        ST_SETTLE = 3'd5
    } state_t;

endpackage

// File: rtl/i2c_write_sequencer_rr_arbiter.sv
// Round-robin picker: searches req starting one past last_grant and reports
// the first set bit. Purely combinational; the sequencer registers the result.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic               en,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    int              cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last_grant) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (en && !grant_valid && req[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/i2c_write_sequencer.sv
// Front end for the single-byte I2C write engine: replays the init table after
// reset, then shares the engine among runtime requesters round-robin.
module i2c_write_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int NUM_INIT       = 4,
    parameter int NUM_REQ        = 2,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        scl_clock,
    input  logic                        reset,
    input  logic [NUM_INIT*ENTRY_W-1:0] init_table,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ENTRY_W-1:0]  req_payload,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic                        eng_start,
    output logic [6:0]                  eng_dev,
    output logic [7:0]                  eng_reg,
    output logic [7:0]                  eng_data,
    input  logic                        eng_done,
    output logic                        init_done,
    output logic                        busy,
    output logic                        timeout_err,
    output state_t                      dbg_state
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int INIT_W = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int ARM_W  = $clog2(ARM_TIMEOUT);

    state_t              state_q;
    logic [INIT_W-1:0]   init_idx_q;
    logic [IDX_W-1:0]    grant_idx_q;
    logic [IDX_W-1:0]    last_grant_q;
    logic [SET_W-1:0]    settle_cnt_q;
    logic [TO_W-1:0]     timeout_cnt_q;
    logic [ARM_W-1:0]    arm_cnt_q;
    logic                eng_start_q;
    logic [6:0]          eng_dev_q;
    logic [7:0]          eng_reg_q;
    logic [7:0]          eng_data_q;
    logic [NUM_REQ-1:0]  req_ack_q;
    logic                init_done_q;
    logic                timeout_err_q;

    logic [ENTRY_W-1:0]  init_entry [NUM_INIT];
    logic [ENTRY_W-1:0]  req_entry  [NUM_REQ];
    logic [ENTRY_W-1:0]  load_entry;
    logic                arb_en;
    logic                grant_valid;
    logic [IDX_W-1:0]    grant_idx;

    for (genvar g = 0; g < NUM_INIT; g++) begin : g_init
        assign init_entry[g] = init_table[g*ENTRY_W +: ENTRY_W];
    end
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign req_entry[g] = req_payload[g*ENTRY_W +: ENTRY_W];
    end

    assign load_entry = init_done_q ? req_entry[grant_idx_q] : init_entry[init_idx_q];
    assign arb_en     = (state_q == ST_IDLE) && init_done_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req         (req),
        .last_grant  (last_grant_q),
        .en          (arb_en),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge scl_clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            init_idx_q    <= '0;
            grant_idx_q   <= '0;
            last_grant_q  <= IDX_W'(NUM_REQ - 1);
            settle_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            arm_cnt_q     <= '0;
            eng_start_q   <= 1'b0;
            eng_dev_q     <= '0;
            eng_reg_q     <= '0;
            eng_data_q    <= '0;
            req_ack_q     <= '0;
            init_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            req_ack_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (!init_done_q) begin
                        state_q <= ST_LOAD;
                    end else if (grant_valid) begin
                        grant_idx_q  <= grant_idx;
                        last_grant_q <= grant_idx;
                        state_q      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Payload is frozen here until the next LOAD; the engine shifts it out serially.
                    eng_dev_q   <= load_entry[DEV_LSB  +: 7];
                    eng_reg_q   <= load_entry[REG_LSB  +: 8];
                    eng_data_q  <= load_entry[DATA_LSB +: 8];
                    eng_start_q <= 1'b1;
                    state_q     <= ST_START;
                end
                ST_START: begin
                    arm_cnt_q <= '0;
                    state_q   <= ST_ARM;
                end
                ST_ARM: begin
                    if (!eng_done) begin
                        timeout_cnt_q <= '0;
                        state_q       <= ST_RUN;
                    end else if (arm_cnt_q == ARM_W'(ARM_TIMEOUT - 1)) begin
                        timeout_err_q <= 1'b1;
                        settle_cnt_q  <= '0;
                        state_q       <= ST_SETTLE;
                    end else begin
                        arm_cnt_q <= arm_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (eng_done || (timeout_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
                        if (!eng_done) begin
                            timeout_err_q <= 1'b1;
                        end
                        if (init_done_q) begin
                            req_ack_q <= NUM_REQ'(1) << grant_idx_q;
                        end
                        settle_cnt_q <= '0;
                        state_q      <= ST_SETTLE;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                        state_q <= ST_IDLE;
                        if (!init_done_q) begin
                            if (init_idx_q == INIT_W'(NUM_INIT - 1)) begin
                                init_done_q <= 1'b1;
                            end else begin
                                init_idx_q <= init_idx_q + 1'b1;
                            end
                        end
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign eng_start   = eng_start_q;
    assign eng_dev     = eng_dev_q;
    assign eng_reg     = eng_reg_q;
    assign eng_data    = eng_data_q;
    assign req_ack     = req_ack_q;
    assign init_done   = init_done_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Bench for i2c_write_sequencer with a behavioural write-engine model and a
// payload scoreboard checked on every engine start.
module tb_i2c_write_sequencer;
  import i2c_seq_pkg::*;

  localparam int NUM_INIT = 2;
  localparam int NUM_REQ = 2;
  localparam int SETTLE = 16;
  localparam int TIMEOUT = 64;
  localparam int ENG_LAT = 8;
  localparam logic [22:0] INIT0 = {7'h68, 8'h6B, 8'h00};
  localparam logic [22:0] INIT1 = {7'h68, 8'h1C, 8'h08};

  logic scl_clock = 1'b0;
  logic reset = 1'b1;
  logic [NUM_INIT*23-1:0] init_table;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*23-1:0] req_payload;
  logic [NUM_REQ-1:0] req_ack;
  logic eng_start;
  logic [6:0] eng_dev;
  logic [7:0] eng_reg;
  logic [7:0] eng_data;
  logic eng_done;
  logic init_done;
  logic busy;
  logic timeout_err;
  state_t dbg_state;

  i2c_write_sequencer #(
    .NUM_INIT(NUM_INIT),
    .NUM_REQ(NUM_REQ),
    .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .scl_clock(scl_clock),
    .reset(reset),
    .init_table(init_table),
    .req(req),
    .req_payload(req_payload),
    .req_ack(req_ack),
    .eng_start(eng_start),
    .eng_dev(eng_dev),
    .eng_reg(eng_reg),
    .eng_data(eng_data),
    .eng_done(eng_done),
    .init_done(init_done),
    .busy(busy),
    .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 scl_clock = ~scl_clock;

  // engine model: 0 = normal ACKing engine, 1 = done stuck high, 2 = done stuck low
  int eng_mode = 0;
  int eng_cnt;
  always @(posedge scl_clock) begin
    if (reset) begin
      eng_done <= 1'b1;
      eng_cnt <= 0;
    end else if (eng_mode == 1) begin
      eng_done <= 1'b1;
    end else if (eng_mode == 2) begin
      eng_done <= 1'b0;
      eng_cnt <= 0;
    end else if (eng_start) begin
      eng_done <= 1'b0;
      eng_cnt <= ENG_LAT;
    end else if (!eng_done) begin
      if (eng_cnt == 0) eng_done <= 1'b1;
      else eng_cnt <= eng_cnt - 1;
    end
  end

  // scoreboard and monitors
  logic [22:0] exp_q[$];
  int gap_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_starts = 0;
  int done_rise_cyc = 0;
  int start_wide = 0;
  int ack_wide = 0;
  int ack_in_init = 0;
  int unstable = 0;
  int arm_run = 0, arm_len = 0;
  int run_run = 0, run_len = 0;
  logic prev_start = 1'b0;
  logic prev_done = 1'b1;
  logic [NUM_REQ-1:0] prev_ack = '0;
  logic [22:0] lat_payload = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge scl_clock) begin
    logic [22:0] cur;
    logic [22:0] e;
    cyc++;
    cur = {eng_dev, eng_reg, eng_data};
    if (reset) n_starts = 0;
    if (eng_start && !prev_start) begin
      n_starts++;
      gap_q.push_back(cyc - done_rise_cyc);
      lat_payload = cur;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_start: got payload 0x%0h with empty expected queue", cur);
      end else begin
        e = exp_q.pop_front();
        check("sb_payload", 32'(cur), 32'(e));
      end
    end
    if (eng_start && prev_start) start_wide++;
    if ((req_ack != 0) && (prev_ack != 0)) ack_wide++;
    if ((req_ack != 0) && !init_done) ack_in_init++;
    if (eng_done && !prev_done) done_rise_cyc = cyc;
    if ((dbg_state == ST_ARM || dbg_state == ST_RUN || dbg_state == ST_SETTLE) && cur != lat_payload)
      unstable++;
    if (dbg_state == ST_ARM) arm_run++;
    else if (arm_run != 0) begin arm_len = arm_run; arm_run = 0; end
    if (dbg_state == ST_RUN) run_run++;
    else if (run_run != 0) begin run_len = run_run; run_run = 0; end
    prev_start = eng_start;
    prev_done = eng_done;
    prev_ack = req_ack;
  end

  // driver tasks
  task automatic set_payload(input int sel, input logic [22:0] p);
    if (sel == 0) req_payload[22:0] = p;
    else req_payload[45:23] = p;
  endtask

  task automatic wait_ack(output logic [NUM_REQ-1:0] ack, input int budget);
    ack = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge scl_clock);
      if (req_ack != 0) begin
        ack = req_ack;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL ack_timeout: got no req_ack, required one within %0d cycles", budget);
  endtask

  task automatic wait_state(input state_t s, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge scl_clock);
      if (dbg_state == s) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: state %0d, required %0d within %0d cycles", name, dbg_state, s, budget);
  endtask

  task automatic wait_start(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge scl_clock);
      if (eng_start) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL start_timeout: got no eng_start within %0d cycles", budget);
  endtask

  task automatic wait_init_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge scl_clock);
      if (init_done) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL init_done_timeout: init_done=0, required 1 within %0d cycles", budget);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_eng_start"}, 32'(eng_start), 0);
    check({tag, "_eng_payload"}, 32'({eng_dev, eng_reg, eng_data}), 0);
    check({tag, "_req_ack"}, 32'(req_ack), 0);
    check({tag, "_init_done"}, 32'(init_done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  typedef struct {
    int sel;
    logic [22:0] payload;
    logic [NUM_REQ-1:0] exp_ack;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [NUM_REQ-1:0] a;
    logic [22:0] p0, pa, pb, pc, pd, pe;
    int last_g;
    int g;
    int expg[4];
    int gap;
    int t;

    vecs[0] = '{1, 23'($urandom_range(0, 32'h7FFFFF)), 2'b10};
    vecs[1] = '{0, 23'($urandom_range(0, 32'h7FFFFF)), 2'b01};
    vecs[2] = '{0, 23'($urandom_range(0, 32'h7FFFFF)), 2'b01};
    vecs[3] = '{1, 23'($urandom_range(0, 32'h7FFFFF)), 2'b10};
    p0 = {7'h3C, 8'hA5, 8'h5A};
    pa = 23'($urandom_range(0, 32'h7FFFFF));
    pb = 23'($urandom_range(0, 32'h7FFFFF));
    pc = 23'($urandom_range(0, 32'h7FFFFF));
    pd = 23'($urandom_range(0, 32'h7FFFFF));
    pe = 23'($urandom_range(0, 32'h7FFFFF));

    // reset with req[0] held from the start
    init_table = {INIT1, INIT0};
    req_payload = '0;
    set_payload(0, p0);
    req = 2'b01;
    reset = 1'b1;
    repeat (3) @(negedge scl_clock);
    check_reset_values("reset");
    exp_q.push_back(INIT0);
    exp_q.push_back(INIT1);
    exp_q.push_back(p0);
    reset = 1'b0;

    // init replay, then the held request is served first
    wait_init_done(500);
    check("init_start_count", 32'(n_starts), 2);
    check("ack_during_init", 32'(ack_in_init), 0);
    wait_ack(a, 300);
    check("held_req0_ack", 32'(a), 32'(2'b01));
    req = '0;
    last_g = 0;

    // table-driven single requests with random payloads
    for (int i = 0; i < 4; i++) begin
      set_payload(vecs[i].sel, vecs[i].payload);
      exp_q.push_back(vecs[i].payload);
      req[vecs[i].sel] = 1'b1;
      wait_ack(a, 300);
      check($sformatf("vec%0d_ack", i), 32'(a), 32'(vecs[i].exp_ack));
      req = '0;
      last_g = vecs[i].sel;
      @(negedge scl_clock);
    end

    // round robin with both requests held
    set_payload(0, pa);
    set_payload(1, pb);
    gap_q.delete();
    g = last_g;
    for (int k = 0; k < 4; k++) begin
      g = (g + 1) % NUM_REQ;
      expg[k] = g;
      exp_q.push_back((g == 0) ? pa : pb);
    end
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(a, 300);
      check($sformatf("rr%0d_ack", k), 32'(a), (expg[k] == 0) ? 32'd1 : 32'd2);
    end
    req = '0;
    last_g = expg[3];
    check("rr_gap_count", 32'(gap_q.size()), 4);
    if (gap_q.size() > 0) void'(gap_q.pop_front());
    while (gap_q.size() > 0) begin
      gap = gap_q.pop_front();
      check("rr_done_to_start_gap", 32'(gap), 32'(SETTLE + 3));
    end

    // engine stuck idle: ARM timeout
    eng_mode = 1;
    set_payload(0, pc);
    exp_q.push_back(pc);
    req[0] = 1'b1;
    wait_start(100);
    req = '0;
    wait_state(ST_SETTLE, 50, "arm_to_settle");
    @(negedge scl_clock);
    check("arm_timeout_len", 32'(arm_len), 32'(ARM_TIMEOUT));
    check("arm_timeout_err", 32'(timeout_err), 1);
    wait_state(ST_IDLE, 50, "arm_to_idle");
    check("arm_idle_busy", 32'(busy), 0);
    eng_mode = 0;

    // sequence continues after the timeout
    set_payload(1, pd);
    exp_q.push_back(pd);
    req[1] = 1'b1;
    wait_ack(a, 300);
    check("after_timeout_ack", 32'(a), 32'(2'b10));
    check("timeout_err_sticky", 32'(timeout_err), 1);
    req = '0;

    // reset clears the error, then reset again mid-RUN of the second init entry
    @(negedge scl_clock);
    reset = 1'b1;
    @(negedge scl_clock);
    check("reset_clears_timeout_err", 32'(timeout_err), 0);
    reset = 1'b0;
    exp_q.push_back(INIT0);
    exp_q.push_back(INIT1);
    t = 0;
    while (!(n_starts == 2 && dbg_state == ST_RUN) && t < 300) begin
      @(negedge scl_clock);
      t++;
    end
    check("reached_init1_run", 32'(t < 300), 1);
    reset = 1'b1;
    @(negedge scl_clock);
    check_reset_values("midrun");
    check("midrun_queue_drained", 32'(exp_q.size()), 0);
    reset = 1'b0;
    exp_q.push_back(INIT0);
    exp_q.push_back(INIT1);
    wait_init_done(500);
    check("reinit_start_count", 32'(n_starts), 2);

    // engine never finishes: RUN timeout still acks
    eng_mode = 2;
    set_payload(1, pe);
    exp_q.push_back(pe);
    req[1] = 1'b1;
    wait_ack(a, TIMEOUT + 100);
    @(negedge scl_clock);
    check("run_timeout_ack", 32'(a), 32'(2'b10));
    check("run_timeout_len", 32'(run_len), 32'(TIMEOUT));
    check("run_timeout_err", 32'(timeout_err), 1);
    req = '0;
    eng_mode = 0;
    wait_state(ST_IDLE, 100, "run_to_idle");

    // end-of-run monitors
    repeat (5) @(negedge scl_clock);
    check("start_width", 32'(start_wide), 0);
    check("ack_width", 32'(ack_wide), 0);
    check("payload_stable", 32'(unstable), 0);
    check("ack_during_init_final", 32'(ack_in_init), 0);
    check("sb_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
